pwm_decoder: RTL
================

Name: pwm_decoder

Overview:
Receive-side counterpart of the PWM generator. The generator's Counter sweeps an address 0..max_value-1 and the output is compared against it. This block samples an incoming PWM waveform, synchronises it, and measures high time and period in clock cycles. It publishes duty and period once per PWM period, with a single-cycle valid strobe. It also detects a stuck-low or stuck-high line (0 % / 100 % duty) through a timeout.

Parameters:
count_width, 7, width of the duty/period outputs and internal counters.
max_value, 100, nominal PWM period in cycles; reported as period (and as duty when stuck high) on timeout.
max_period, 120, cycles without a rising edge before timeout; max_value < max_period < 2^count_width.
sync_stages, 2, input synchroniser depth (>= 2).

Ports:
Clk  input  1  system clock, rising-edge.
Rst  input  1  asynchronous, active-low reset.
pwm_in  input  1  asynchronous PWM input.
duty  output  count_width  measured high cycles of the last complete period.
period  output  count_width  measured cycles between the last two rising edges.
valid  output  1  one-cycle strobe: duty/period/timeout updated.
timeout  output  1  1 = last report came from a timeout (stuck line).

Behaviour:
- Reset (Rst=0, asynchronous):
  - duty=0, period=0, valid=0, timeout=0.
  - Sync flops and edge register = 0; per_cnt = high_cnt = 0; state=WAIT.
- Synchroniser:
  - s = output of the sync_stages flop chain; s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- Latency: valid rises sync_stages+1 clock edges after the first edge that samples pwm_in high (3 with defaults).
- FSM states WAIT, HIGH, LOW. per_cnt increments every cycle unless stated otherwise.
- WAIT:
  - On rise: per_cnt<=1, high_cnt<=1, go to HIGH, no report.
  - Otherwise, when per_cnt==max_period-1: timeout report, per_cnt<=0, stay in WAIT.
- HIGH:
  - high_cnt increments while s=1.
  - On fall: go to LOW (high_cnt not incremented on that cycle).
  - When per_cnt==max_period-1: timeout report, go to WAIT, per_cnt<=0.
- LOW:
  - On rise: duty<=high_cnt, period<=per_cnt, timeout<=0, valid<=1; per_cnt<=1, high_cnt<=1; go to HIGH.
  - When per_cnt==max_period-1 with no rise: timeout report, go to WAIT.
- Timeout report:
  - valid<=1, timeout<=1, period<=max_value.
  - duty<=max_value if s=1, else 0.
  - While the line stays stuck, a report repeats every max_period cycles.
- Priority: rise beats timeout on the same cycle.
- Measurement rules:
  - The first measurement follows the second observed rising edge.
  - A waveform with P cycles per period and H high cycles reports period=P, duty=H exactly (the synchroniser delay cancels).
- Outputs are registered and hold their value between valid strobes. valid is high for exactly one cycle per report.
- Counters never exceed max_period-1, so there is no wrap-around.
- Reset mid-measurement discards the partial period; no stale valid follows.
- If pwm_in is high at reset release, the rise is detected after sync_stages cycles and measurement starts from it.

Test Plan:
- pwm_in 25 high / 75 low, 4 periods, 2 ns clock -> first valid 3 cycles after the 2nd input rise; duty=25, period=100, timeout=0; exactly one valid per period.
- Duty changes from 25 to 75 mid-stream (period 100) -> next report duty=75, period=100; the following report is unchanged.
- pwm_in held 0 for 300 cycles after reset -> valid at cycles 120 and 240; duty=0, period=100, timeout=1.
- pwm_in held 1 after one rise -> timeout report 120 cycles after that rise with duty=100, period=100, timeout=1; a normal waveform resuming clears timeout=0 on its second rise.
- Short waveform, 1 high / 9 low -> duty=1, period=10; valid pulses 10 cycles apart.
- Rst=0 for 3 cycles during HIGH -> duty/period/valid/timeout = 0 immediately (asynchronous); after release, no valid until the second new rise, which reports the correct values.

Source files
------------

// File: rtl/pwm_decoder.sv
// PWM receiver: synchronises pwm_in, measures high time and period between rising
// edges, and reports stuck-low / stuck-high lines through a period timeout.
module pwm_decoder #(
    parameter int unsigned count_width = 7,
    parameter int unsigned max_value   = 100,
    parameter int unsigned max_period  = 120,
    parameter int unsigned sync_stages = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   pwm_in,
    output logic [count_width-1:0] duty,
    output logic [count_width-1:0] period,
    output logic                   valid,
    output logic                   timeout,
    output logic [1:0]             state_dbg
);

    localparam logic [count_width-1:0] MAX_VAL = count_width'(max_value);
    localparam logic [count_width-1:0] LIMIT   = count_width'(max_period - 1);
    localparam logic [count_width-1:0] ONE     = count_width'(1);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [sync_stages-1:0]   sync_q;
    logic                     s;
    logic                     s_d;
    logic                     rise;
    logic                     fall;
    logic                     at_limit;
    logic [count_width-1:0]   per_cnt;
    logic [count_width-1:0]   per_nxt;
    logic [count_width-1:0]   high_cnt;
    logic [count_width-1:0]   high_nxt;
    logic                     rep;
    logic                     rep_to;
    logic [count_width-1:0]   rep_duty;
    logic [count_width-1:0]   rep_period;

    // Input synchroniser plus one extra flop for edge detection.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], pwm_in};
            s_d    <= s;
        end
    end

    assign s        = sync_q[sync_stages-1];
    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;
    assign at_limit = (per_cnt == LIMIT);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= WAIT;
            per_cnt  <= '0;
            high_cnt <= '0;
        end else begin
            state    <= state_nxt;
            per_cnt  <= per_nxt;
            high_cnt <= high_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        per_nxt    = per_cnt + ONE;
        high_nxt   = high_cnt;
        rep        = 1'b0;
        rep_to     = 1'b0;
        rep_duty   = '0;
        rep_period = '0;
        case (state)
            WAIT: begin
                if (rise) begin
                    per_nxt   = ONE;
                    high_nxt  = ONE;
                    state_nxt = HIGH;
                end else if (at_limit) begin
                    rep     = 1'b1;
                    rep_to  = 1'b1;
                    per_nxt = '0;
                end
            end
            HIGH: begin
                if (at_limit) begin
                    rep       = 1'b1;
                    rep_to    = 1'b1;
                    per_nxt   = '0;
                    state_nxt = WAIT;
                end else if (fall) begin
                    state_nxt = LOW;
                end else if (s) begin
                    high_nxt = high_cnt + ONE;
                end
            end
            LOW: begin
                // A rise closes the period and wins over a coincident timeout.
                if (rise) begin
                    rep        = 1'b1;
                    rep_duty   = high_cnt;
                    rep_period = per_cnt;
                    per_nxt    = ONE;
                    high_nxt   = ONE;
                    state_nxt  = HIGH;
                end else if (at_limit) begin
                    rep       = 1'b1;
                    rep_to    = 1'b1;
                    per_nxt   = '0;
                    state_nxt = WAIT;
                end
            end
            default: begin
                state_nxt = WAIT;
                per_nxt   = '0;
                high_nxt  = '0;
            end
        endcase
        if (rep_to) begin
            rep_duty   = s ? MAX_VAL : '0;
            rep_period = MAX_VAL;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            duty    <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= rep;
            if (rep) begin
                duty    <= rep_duty;
                period  <= rep_period;
                timeout <= rep_to;
            end
        end
    end

    assign state_dbg = state;

endmodule
